// File: rtl/pool_collector.sv
// 2x2/stride-1 max-pool collector for a 3x3 signed map, with a result FIFO.
// Optional build macro POOL_COLLECTOR_RELU_EN clamps negative samples to 0.
module pool_collector #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       clear,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_done
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [1:0]        row_reg;
   logic [1:0]        col_reg;
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic              frame_done_reg;
   logic signed [7:0] prev_row_reg [3];
   logic signed [7:0] cur_row_reg [3];
   logic signed [7:0] fifo_mem_reg [FIFO_DEPTH];

   logic              accept;
   logic              push;
   logic              pop;
   logic signed [7:0] px;
   logic signed [7:0] win_a;
   logic signed [7:0] win_b;
   logic signed [7:0] win_c;
   logic signed [7:0] win_max;

   function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                              input logic signed [7:0] b);
      return (a > b) ? a : b;
   endfunction

`ifdef POOL_COLLECTOR_RELU_EN
   assign px = in_data[7] ? 8'sd0 : $signed(in_data);
`else
   assign px = $signed(in_data);
`endif

   assign in_ready   = (count_reg < CW'(FIFO_DEPTH));
   assign out_valid  = (count_reg != '0);
   assign out_data   = out_valid ? fifo_mem_reg[rd_ptr_reg] : 8'd0;
   assign frame_done = frame_done_reg;

   // clear wins over any accept or pop in the same cycle
   assign accept = in_valid && in_ready && !clear;
   assign push   = accept && (row_reg != 2'd0) && (col_reg != 2'd0);
   assign pop    = out_valid && out_ready && !clear;

   // window columns col-1 and col; col is 1 or 2 whenever a push happens
   always_comb begin
      win_a = prev_row_reg[0];
      win_b = prev_row_reg[1];
      win_c = cur_row_reg[0];
      if (col_reg == 2'd2) begin
         win_a = prev_row_reg[1];
         win_b = prev_row_reg[2];
         win_c = cur_row_reg[1];
      end
      win_max = smax(smax(win_a, win_b), smax(win_c, px));
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         row_reg        <= 2'd0;
         col_reg        <= 2'd0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         frame_done_reg <= 1'b0;
      end else if (clear) begin
         row_reg        <= 2'd0;
         col_reg        <= 2'd0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= accept && (row_reg == 2'd2) && (col_reg == 2'd2);
         if (accept) begin
            if (col_reg == 2'd2) begin
               col_reg <= 2'd0;
               row_reg <= (row_reg == 2'd2) ? 2'd0 : row_reg + 2'd1;
            end else begin
               col_reg <= col_reg + 2'd1;
            end
         end
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // line buffers: the finished current row becomes the previous row on wrap
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 3; i++) begin
            prev_row_reg[i] <= 8'sd0;
            cur_row_reg[i]  <= 8'sd0;
         end
      end else if (accept) begin
         for (int i = 0; i < 3; i++) begin
            if (col_reg == 2'(i))
               cur_row_reg[i] <= px;
            if (col_reg == 2'd2)
               prev_row_reg[i] <= (i == 2) ? px : cur_row_reg[i];
         end
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifo_mem_reg[i] <= 8'sd0;
      end else if (push) begin
         fifo_mem_reg[wr_ptr_reg] <= win_max;
      end
   end

endmodule
